// File: rtl/centroid_update_controller_pkg.sv
// k-means centroid-update shared widths, types and FSM state encoding.
// Imported by the interface, the controller and the packing sub-module.
package k_means_pkg;

  localparam int centroid_num       = 8;
  localparam int coord_num          = 7;
  localparam int accum_cord_width   = 22;
  localparam int cordinate_width    = 13;
  localparam int count_width        = 10;
  localparam int addrWidth          = 8;
  localparam int dataWidth          = coord_num * cordinate_width;
  localparam int centroid_base_addr = 0;

  localparam int CIW = $clog2(centroid_num);
  localparam int KIW = $clog2(coord_num);

  typedef logic [cordinate_width-1:0]            coord_t;
  typedef logic [accum_cord_width-1:0]           acc_t;
  typedef logic [count_width-1:0]                cnt_t;
  typedef logic [CIW-1:0]                        cidx_t;
  typedef logic [KIW-1:0]                        kidx_t;
  typedef logic [addrWidth-1:0]                  addr_t;
  typedef logic [dataWidth-1:0]                  word_t;
  typedef logic [coord_num*accum_cord_width-1:0] sums_t;

  typedef enum logic [3:0] {
    IDLE,
    RD_ACC,
    LATCH,
    CHECK,
    DIV_ISSUE,
    DIV_WAIT,
    WRITE,
    NEXT,
    DONE
  } cu_state_t;

  localparam cidx_t C_LAST = cidx_t'(centroid_num - 1);
  localparam kidx_t K_LAST = kidx_t'(coord_num - 1);
  localparam addr_t BASE   = addr_t'(centroid_base_addr);

endpackage

// File: rtl/centroid_update_controller_if.sv
// Bundle of start/status, accumulator-read, divider and centroid-RAM signals.
// master: controller side; slave: k-means top / accumulators / divider / RAM side.
interface centroid_update_controller_if;
  import k_means_pkg::*;

  logic  start;
  logic  busy;
  logic  done;
  logic  acc_rd_en;
  cidx_t acc_rd_idx;
  sums_t acc_rd_sums;
  cnt_t  acc_rd_count;
  logic  div_start;
  acc_t  div_dividend;
  cnt_t  div_divisor;
  logic  div_done;
  acc_t  div_quotient;
  logic  mem_wr_en;
  addr_t mem_wr_addr;
  word_t mem_wr_data;
  logic  sat_flag;

  modport master (
    input  start, acc_rd_sums, acc_rd_count,
    input  div_done, div_quotient,
    output busy, done, acc_rd_en, acc_rd_idx,
    output div_start, div_dividend, div_divisor,
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    output sat_flag
  );

  modport slave (
    output start, acc_rd_sums, acc_rd_count,
    output div_done, div_quotient,
    input  busy, done, acc_rd_en, acc_rd_idx,
    input  div_start, div_dividend, div_divisor,
    input  mem_wr_en, mem_wr_addr, mem_wr_data,
    input  sat_flag
  );

endinterface

// File: rtl/centroid_update_controller_pack.sv
// Saturates the incoming quotient to coordinate width and packs the slots.
// quot_i/slots_i in; coord_o (saturated), sat_o (clipped), word_o (coord 1 in LSBs).
module centroid_pack
  import k_means_pkg::*;
(
  input  acc_t   quot_i,
  input  coord_t slots_i [coord_num],
  output coord_t coord_o,
  output logic   sat_o,
  output word_t  word_o
);

  assign sat_o   = |quot_i[accum_cord_width-1:cordinate_width];
  assign coord_o = sat_o ? '1 : quot_i[cordinate_width-1:0];

  always_comb begin
    word_o = '0;
    for (int i = 0; i < coord_num; i++) begin
      word_o[i*cordinate_width +: cordinate_width] = slots_i[i];
    end
  end

endmodule

// File: rtl/centroid_update_controller.sv
// Walks the accumulators, divides each sum by its count, writes centroids.
// Ports: clk, rst_n (async active-low), cu (master side of the bundle).
module centroid_update_controller
  import k_means_pkg::*;
(
  input logic clk,
  input logic rst_n,
  centroid_update_controller_if.master cu
);

  cu_state_t state_q, state_d;
  cidx_t     c_q, c_d;
  kidx_t     k_q, k_d;
  logic      sat_q, sat_d;
  acc_t      sum_q  [coord_num];
  coord_t    slot_q [coord_num];
  cnt_t      cnt_q;

  coord_t sat_coord;
  logic   sat_det;
  word_t  packed_w;
  logic   rd_en, ds, wr_en, dn;
  logic   in_div;

  centroid_pack u_pack (
    .quot_i  (cu.div_quotient),
    .slots_i (slot_q),
    .coord_o (sat_coord),
    .sat_o   (sat_det),
    .word_o  (packed_w)
  );

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    k_d     = k_q;
    sat_d   = sat_q;
    rd_en   = 1'b0;
    ds      = 1'b0;
    wr_en   = 1'b0;
    dn      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cu.start) begin
          state_d = RD_ACC;
          c_d     = '0;
          sat_d   = 1'b0;
        end
      end
      RD_ACC: begin
        rd_en   = 1'b1;
        state_d = LATCH;
      end
      LATCH: state_d = CHECK;
      CHECK: begin
        if (cnt_q == '0) begin
          state_d = NEXT;
        end else begin
          k_d     = '0;
          state_d = DIV_ISSUE;
        end
      end
      DIV_ISSUE: begin
        ds      = 1'b1;
        state_d = DIV_WAIT;
      end
      DIV_WAIT: begin
        if (cu.div_done) begin
          sat_d = sat_q | sat_det;
          if (k_q == K_LAST) begin
            state_d = WRITE;
          end else begin
            k_d     = k_q + kidx_t'(1);
            state_d = DIV_ISSUE;
          end
        end
      end
      WRITE: begin
        wr_en   = 1'b1;
        state_d = NEXT;
      end
      NEXT: begin
        if (c_q == C_LAST) begin
          state_d = DONE;
        end else begin
          c_d     = c_q + cidx_t'(1);
          state_d = RD_ACC;
        end
      end
      DONE: begin
        dn      = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      k_q     <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < coord_num; i++) begin
        sum_q[i]  <= '0;
        slot_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      k_q     <= k_d;
      sat_q   <= sat_d;
      if (state_q == LATCH) begin
        cnt_q <= cu.acc_rd_count;
        for (int i = 0; i < coord_num; i++) begin
          sum_q[i] <= cu.acc_rd_sums[i*accum_cord_width +: accum_cord_width];
        end
      end
      if (state_q == DIV_WAIT && cu.div_done) begin
        slot_q[k_q] <= sat_coord;
      end
    end
  end

  // Divider operands are only driven while a divide is outstanding.
  assign in_div = (state_q == DIV_ISSUE) || (state_q == DIV_WAIT);

  assign cu.busy         = (state_q != IDLE);
  assign cu.done         = dn;
  assign cu.acc_rd_en    = rd_en;
  assign cu.acc_rd_idx   = c_q;
  assign cu.div_start    = ds;
  assign cu.div_dividend = in_div ? sum_q[k_q] : '0;
  assign cu.div_divisor  = in_div ? cnt_q : '0;
  assign cu.mem_wr_en    = wr_en;
  assign cu.mem_wr_addr  = wr_en ? (BASE + addr_t'(c_q)) : '0;
  assign cu.mem_wr_data  = wr_en ? packed_w : '0;
  assign cu.sat_flag     = sat_q;

endmodule

// File: tb/tb_centroid_update_controller.sv
// Scoreboard bench: accumulator bank, latency-programmable divider, RAM monitor.
// Expected writes come from a plain-arithmetic model of the centroid update.
module tb_centroid_update_controller;
  import k_means_pkg::*;

  typedef struct {
    logic [addrWidth-1:0] addr;
    logic [dataWidth-1:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  centroid_update_controller_if cu();

  centroid_update_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cu    (cu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  wr_t exp_q[$];
  logic [accum_cord_width-1:0] a_sum [centroid_num][coord_num];
  logic [count_width-1:0]      a_cnt [centroid_num];
  int lat_fixed;
  bit lat_rand;
  int rd_cnt;
  int ds_cnt;
  int wr_cnt;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Accumulator bank: data valid one cycle after the read strobe.
  always @(posedge clk) begin
    if (cu.acc_rd_en) begin
      for (int k = 0; k < coord_num; k++)
        cu.acc_rd_sums[k*accum_cord_width +: accum_cord_width] <=
          a_sum[cu.acc_rd_idx][k];
      cu.acc_rd_count <= a_cnt[cu.acc_rd_idx];
    end
  end

  // Divider with latency L between div_start and div_done.
  int dcnt;
  int lsel;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cu.div_done     <= 1'b0;
      cu.div_quotient <= '0;
      dcnt            <= 0;
    end else begin
      cu.div_done <= 1'b0;
      if (cu.div_start) begin
        lsel = lat_rand ? int'($urandom_range(1, 10)) : lat_fixed;
        if (lsel == 1) begin
          cu.div_done     <= 1'b1;
          cu.div_quotient <= cu.div_dividend / acc_t'(cu.div_divisor);
          dcnt            <= 0;
        end else begin
          dcnt <= lsel - 1;
        end
      end else if (dcnt == 1) begin
        cu.div_done     <= 1'b1;
        cu.div_quotient <= cu.div_dividend / acc_t'(cu.div_divisor);
        dcnt            <= 0;
      end else if (dcnt > 1) begin
        dcnt <= dcnt - 1;
      end
    end
  end

  // Monitor: pops the scoreboard on every RAM write.
  always @(negedge clk) begin
    int p;
    wr_t e;
    if (rst_n) begin
      p = int'(cu.acc_rd_en) + int'(cu.div_start) +
          int'(cu.mem_wr_en) + int'(cu.done);
      if (p > 0) chk("pulse_exclusive", (p > 1), 0);
      if (cu.acc_rd_en) rd_cnt++;
      if (cu.div_start) begin
        ds_cnt++;
        vectors++;
        if (cu.div_divisor == '0) begin
          miscompares++;
          $display("FAIL div_divisor_zero: got 0 expected nonzero");
        end
      end
      if (cu.mem_wr_en) begin
        wr_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: addr %0d data %h, none expected",
                   cu.mem_wr_addr, cu.mem_wr_data);
        end else begin
          e = exp_q.pop_front();
          if (cu.mem_wr_addr !== e.addr || cu.mem_wr_data !== e.data) begin
            miscompares++;
            $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                     cu.mem_wr_addr, cu.mem_wr_data, e.addr, e.data);
          end
        end
      end
    end
  end

  // Reference model: centroid = min(floor(sum/count), 2^w-1) per coord.
  task automatic build_expect(output bit sat);
    wr_t e;
    longint q;
    sat = 1'b0;
    for (int c = 0; c < centroid_num; c++) begin
      if (a_cnt[c] != 0) begin
        e.addr = addrWidth'(centroid_base_addr + c);
        e.data = '0;
        for (int k = 0; k < coord_num; k++) begin
          q = longint'(a_sum[c][k]) / longint'(a_cnt[c]);
          if (q > 8191) begin
            q   = 8191;
            sat = 1'b1;
          end
          e.data[k*cordinate_width +: cordinate_width] = cordinate_width'(q);
        end
        exp_q.push_back(e);
      end
    end
  endtask

  function automatic int exp_cycles(input int L);
    int n;
    n = 1;
    for (int c = 0; c < centroid_num; c++)
      n += (a_cnt[c] == 0) ? 4 : (5 + coord_num * (1 + L));
    return n;
  endfunction

  task automatic clear_bank();
    for (int c = 0; c < centroid_num; c++) begin
      a_cnt[c] = '0;
      for (int k = 0; k < coord_num; k++) a_sum[c][k] = '0;
    end
  endtask

  task automatic run_pass(input string nm, input int ecyc, input bit glitch);
    bit esat;
    int cyc;
    int rd0;
    build_expect(esat);
    rd0 = rd_cnt;
    @(negedge clk);
    cu.start = 1'b1;
    @(negedge clk);
    cu.start = 1'b0;
    chk({nm, "_busy"}, cu.busy, 1);
    chk({nm, "_sat_cleared"}, cu.sat_flag, 0);
    cyc = 1;
    while (!cu.done && cyc < 5000) begin
      cu.start = (glitch && cyc == 20);
      @(negedge clk);
      cyc++;
    end
    cu.start = 1'b0;
    if (cyc >= 5000) begin
      miscompares++;
      $display("FAIL %s_timeout: got no done expected done", nm);
    end
    if (ecyc > 0) chk({nm, "_done_latency"}, cyc, ecyc);
    chk({nm, "_visits"}, rd_cnt - rd0, centroid_num);
    chk({nm, "_sat_flag"}, cu.sat_flag, esat);
    chk({nm, "_writes_left"}, exp_q.size(), 0);
    if (glitch) cu.start = 1'b1;
    @(negedge clk);
    cu.start = 1'b0;
    chk({nm, "_idle_after"}, cu.busy, 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    int ds0;
    bit s;
    vectors     = 0;
    miscompares = 0;
    rd_cnt      = 0;
    ds_cnt      = 0;
    wr_cnt      = 0;
    lat_fixed   = 3;
    lat_rand    = 1'b0;
    cu.start    = 1'b0;
    clear_bank();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", cu.busy, 0);
    chk("rst_done", cu.done, 0);
    chk("rst_outputs", {cu.acc_rd_en, cu.div_start, cu.mem_wr_en,
                        cu.sat_flag}, 0);
    chk("rst_dividend", cu.div_dividend, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single centroid, exact divide, L=3.
    for (int k = 0; k < coord_num; k++) a_sum[0][k] = 22'(400 * (k + 1));
    a_cnt[0] = 10'd4;
    run_pass("exact", 3 + 7 * 4 + 2 + 7 * 4 + 1, 1'b0);

    // Saturation on centroid 3.
    clear_bank();
    a_cnt[3] = 10'd1;
    for (int k = 0; k < coord_num; k++) a_sum[3][k] = 22'(9000 - k * 2000);
    run_pass("saturate", exp_cycles(3), 1'b0);

    // Truncation; this start must clear the sticky flag.
    clear_bank();
    a_cnt[5] = 10'd3;
    for (int k = 0; k < coord_num; k++) a_sum[5][k] = 22'(10 + k);
    run_pass("truncate", exp_cycles(3), 1'b0);

    // All empty plus starts while busy and on the DONE cycle.
    clear_bank();
    ds0 = ds_cnt;
    run_pass("empty", 33, 1'b1);
    chk("empty_no_div", ds_cnt - ds0, 0);

    // Reset during DIV_WAIT of centroid 2.
    lat_fixed = 2;
    for (int c = 0; c < centroid_num; c++) begin
      a_cnt[c] = 10'(2 + c);
      for (int k = 0; k < coord_num; k++)
        a_sum[c][k] = 22'($urandom_range(0, 5000));
    end
    build_expect(s);
    @(negedge clk);
    cu.start = 1'b1;
    @(negedge clk);
    cu.start = 1'b0;
    n = 0;
    while (!(cu.acc_rd_en && cu.acc_rd_idx == 3'd2) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    while (!cu.div_start && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (n >= 2000) begin
      miscompares++;
      $display("FAIL abort_reach_timeout: got no centroid 2 divide expected one");
    end
    chk("abort_writes_before", exp_q.size(), centroid_num - 2);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", cu.busy, 0);
    chk("abort_pulses", {cu.acc_rd_en, cu.div_start, cu.mem_wr_en,
                         cu.done}, 0);
    chk("abort_bus", {cu.div_dividend, cu.mem_wr_addr}, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_done", cu.done, 0);
    run_pass("after_abort", exp_cycles(2), 1'b0);

    // Random counts and sums; one pass at L=1 with latency check.
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < centroid_num; c++) begin
        a_cnt[c] = ($urandom_range(0, 3) == 0) ? 10'd0 :
                   10'($urandom_range(1, 1023));
        for (int k = 0; k < coord_num; k++)
          a_sum[c][k] = 22'($urandom);
      end
      if (p == 0) begin
        lat_rand  = 1'b0;
        lat_fixed = 1;
        run_pass("rand_l1", exp_cycles(1), 1'b0);
      end else begin
        lat_rand = 1'b1;
        run_pass("rand", 0, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/centroid_update_controller.md
# centroid_update_controller

Sequences the k-means centroid-update phase. After the accumulation pass, it walks the per-centroid accumulators. For each centroid it pushes every coordinate sum through one shared sequential divider, dividing by the point count. It then saturates the quotients to coordinate width, packs them into one centroid word and writes that word to centroid memory. Centroids with zero points keep their old memory value. The block sits between the accumulator bank, the shared divider and the centroid RAM, and is started by the top-level k-means FSM.

## Interface
- centroid_num, 8, number of centroids processed per pass
- coord_num, 7, coordinates per centroid
- accum_cord_width, 22, width of one accumulated coordinate sum
- cordinate_width, 13, width of one stored coordinate
- count_width, 10, point-count width
- addrWidth, 8, centroid memory address width
- dataWidth, 91, centroid word width; must equal coord_num*cordinate_width
- centroid_base_addr, 0, memory address of centroid 0
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse that begins a pass; ignored while busy
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse when the pass completes
- acc_rd_en  out  1  accumulator read strobe
- acc_rd_idx  out  $clog2(centroid_num)  accumulator index being read
- acc_rd_sums  in  coord_num*accum_cord_width  sums, coord 1 in LSBs; valid one cycle after acc_rd_en
- acc_rd_count  in  count_width  point count; valid with acc_rd_sums
- div_start  out  1  one-cycle request to the divider
- div_dividend  out  accum_cord_width  held stable from div_start until div_done
- div_divisor  out  count_width  held stable from div_start until div_done; never 0 when div_start is asserted
- div_done  in  1  quotient valid; arrives at least 1 cycle after div_start
- div_quotient  in  accum_cord_width  unsigned quotient
- mem_wr_en  out  1  centroid write strobe
- mem_wr_addr  out  addrWidth  centroid_base_addr + centroid index
- mem_wr_data  out  dataWidth  packed centroid, coord 1 at [cordinate_width-1:0]
- sat_flag  out  1  sticky per pass: some quotient was saturated; cleared on accepted start

## Operation
- FSM states: IDLE, RD_ACC, LATCH, CHECK, DIV_ISSUE, DIV_WAIT, WRITE, NEXT, DONE.
- **IDLE:** on start, go to RD_ACC. Set centroid index c=0 and clear sat_flag.
- **RD_ACC:** assert acc_rd_en with acc_rd_idx=c.
- **LATCH:** register acc_rd_sums and acc_rd_count.
- **CHECK:**
  - If count==0, go to NEXT with no divide and no write; the old centroid is preserved.
  - Otherwise set coordinate index k=0 and go to DIV_ISSUE.
- **DIV_ISSUE:** pulse div_start. Drive div_dividend = sum[k] and div_divisor = count.
- **DIV_WAIT:** wait for div_done, then store the saturated quotient in slot k.
  - Saturation: if quotient ≥ 2^cordinate_width, store all-ones and set sat_flag; otherwise store quotient[cordinate_width-1:0].
  - If k < coord_num-1, increment k and go to DIV_ISSUE. Otherwise go to WRITE.
- **WRITE:** one-cycle mem_wr_en with the packed word.
- **NEXT:** if c == centroid_num-1, go to DONE. Otherwise increment c and go to RD_ACC.
- **DONE:** done=1 for one cycle, then IDLE.
- All arithmetic is unsigned. No rounding: the result is the truncated quotient.

## Timing
- Reset value of every output is 0. The reset forces IDLE, clears c, k, the quotient slots and sat_flag.
- Reset asserted mid-pass aborts immediately: no write is issued and no done pulse is produced.
- With divider latency L (div_start to div_done), a non-empty centroid takes 3 + coord_num·(1+L) + 2 cycles. An empty centroid takes 4 cycles.
- A start that coincides with the DONE cycle, or arrives during busy, is dropped.
- div_done received outside DIV_WAIT is ignored.
- mem_wr_en, div_start, acc_rd_en and done are each a single-cycle pulse and are never asserted in the same cycle.

## Structure
- Package k_means_pkg holds:
  - the width constants (accum_cord_width, cordinate_width, count_width, coord_num, centroid_num);
  - typedef coord_t (cordinate_width bits);
  - typedef acc_t (accum_cord_width bits);
  - typedef enum cu_state_t for the FSM.
- Sub-module centroid_pack: combinational saturation plus concatenation of the coord_num quotient slots into mem_wr_data. It also outputs the saturation detect for the current slot.

## Test plan
- **Single centroid, exact divide:** centroid 0 with count=4 and sums 400, 800, …, 2800; others count=0; divider L=3.
  - Expect exactly one write, at address 0, with coords 100, 200, …, 700.
  - Expect done after 3+7·4+2+7·4+1 cycles.
- **Truncation:** count=3, sum=10 → coord 3; sat_flag=0.
- **Saturation:** count=1, sum=9000 → coord 8191 and sat_flag=1. A later start clears sat_flag.
- **All empty:** every count=0 → no div_start, no mem_wr_en, and done exactly 33 cycles after start.
- **Robustness:**
  - start pulsed while busy → ignored, with exactly 8 centroid visits.
  - rst_n dropped during DIV_WAIT of centroid 2 → outputs 0 asynchronously and no write for centroid 2.
  - A new start then completes normally.
- **Variable divider latency:** random L of 1–10 and random counts 1–1023 → every written coord equals min(sum/count, 8191), checked against a reference model.
